// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_responder
//  Description : MEM-stage word responder with fixed access latency, a one-cycle
//                ready pulse and an error flag for misaligned/out-of-range access.
//  Revision    : 1.0  initial release
// ============================================================================
module data_mem_responder #(
    parameter int ADDR_W   = 8,
    parameter int WAIT_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy
);

    localparam int c_DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cnt_nxt;
    logic                r_we;
    logic [31:0]         r_addr;
    logic [31:0]         r_wdata;
    logic [31:0]         r_rdata;
    logic [31:0]         w_rdata_nxt;
    logic                r_ready;
    logic                w_ready_nxt;
    logic                r_err;
    logic                w_err_nxt;
    logic                r_busy;
    logic                w_busy_nxt;
    logic                w_latch;
    logic                w_access;
    logic                w_legal;
    logic [ADDR_W-1:0]   w_idx;
    logic [31:0]         r_mem [c_DEPTH];

    // Decode works only on the latched request; live inputs are ignored past IDLE.
    assign w_legal  = (r_addr[1:0] == 2'b00) && (r_addr[31:ADDR_W+2] == '0);
    assign w_idx    = r_addr[ADDR_W+1:2];
    assign w_latch  = (r_state == S_IDLE) && req;
    assign w_access = (r_state == S_WAIT) && (r_cnt == 4'd0);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rdata_nxt = r_rdata;
        w_ready_nxt = 1'b0;
        w_err_nxt   = 1'b0;
        w_busy_nxt  = r_busy;
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = 4'(WAIT_CYC);
                    w_busy_nxt  = 1'b1;
                end
            end
            S_WAIT: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    w_state_nxt = S_RESP;
                    w_ready_nxt = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_err_nxt   = ~w_legal;
                    w_rdata_nxt = (w_legal && !r_we) ? r_mem[w_idx] : 32'd0;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_rdata <= 32'd0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rdata <= w_rdata_nxt;
            r_ready <= w_ready_nxt;
            r_err   <= w_err_nxt;
            r_busy  <= w_busy_nxt;
            if (w_latch) begin
                r_we    <= we;
                r_addr  <= addr;
                r_wdata <= wdata;
            end
        end
    end

    // Array is never reset; reset forces IDLE asynchronously, so no commit can follow.
    always_ff @(posedge clk) begin
        if (w_access && r_we && w_legal) begin
            r_mem[w_idx] <= r_wdata;
        end
    end

    assign rdata = r_rdata;
    assign ready = r_ready;
    assign err   = r_err;
    assign busy  = r_busy;

endmodule
`default_nettype wire
